// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants and state encoding for the binary-to-BCD converter
package bcd_pkg;
  localparam int DW = 4;
  localparam int W_DEF = 10;
  localparam int NDIG_DEF = 4;
  localparam int LIM_DEF = 999;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: digit correction step, adds 3 to a BCD digit of 5 or more before it is doubled
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);
  assign q = d >= DW'(5) ? d + DW'(3) : d;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: iterative double-dabble binary to packed BCD converter, one bit per clock
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int NDIG = NDIG_DEF,
  parameter int LIM = LIM_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [W-1:0]       bin,
  output logic               busy,
  output logic               done,
  output logic [DW*NDIG-1:0] bcd,
  output logic               ovf3
);
  localparam int AW = DW * NDIG;
  localparam int CW = W > 1 ? $clog2(W) : 1;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [W-1:0] sh;
  logic [AW-1:0] acc, adj, acc_nx;
  logic ovf3_n, last;
  genvar i;
  for (i = 0; i < NDIG; i++) begin : g_dig
    bcd_add3 u_add3 (.d(acc[DW*i +: DW]), .q(adj[DW*i +: DW]));
  end
  assign acc_nx = {adj[AW-2:0], sh[W-1]};
  assign last = cnt == CW'(W - 1);
  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else state <= state_n;
  end
  // Next state and handshake outputs; only IDLE accepts a start
  always_comb begin
    state_n = state == S_IDLE ? (start ? S_SHIFT : S_IDLE) :
              state == S_SHIFT ? (last ? S_DONE : S_SHIFT) : S_IDLE;
    busy = state != S_IDLE;
    done = state == S_DONE;
  end
  // Datapath: capture operand on accept, correct and shift while converting, publish on final shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh <= '0;
      acc <= '0;
      cnt <= '0;
      ovf3_n <= 1'b0;
      bcd <= '0;
      ovf3 <= 1'b0;
    end else if (state == S_IDLE && start) begin
      sh <= bin;
      acc <= '0;
      cnt <= '0;
      ovf3_n <= bin > W'(LIM);
    end else if (state == S_SHIFT) begin
      sh <= sh << 1;
      acc <= acc_nx;
      cnt <= cnt + 1'b1;
      if (last) begin
        bcd <= acc_nx;
        ovf3 <= ovf3_n;
      end
    end
  end
endmodule
